// File: rtl/s_to_p_pack_if.sv
// s_to_p_pack_if: slice input and packed-word output bundle for the serial-to-parallel packer
interface s_to_p_pack_if #(
  parameter int N_SLICES   = 4,
  parameter int SLICE_SIZE = 32,
  parameter int CNT_W      = 16
);
  logic                           ce;
  logic                           sync;
  logic [SLICE_SIZE-1:0]          din;
  logic                           din_vld;
  logic                           eof;
  logic [N_SLICES*SLICE_SIZE-1:0] dout;
  logic                           dout_vld;
  logic [N_SLICES-1:0]            dout_mask;
  logic                           dout_last;
  logic [CNT_W-1:0]               dropped;
  modport master (
    output ce, sync, din, din_vld, eof,
    input  dout, dout_vld, dout_mask, dout_last, dropped
  );
  modport slave (
    input  ce, sync, din, din_vld, eof,
    output dout, dout_vld, dout_mask, dout_last, dropped
  );
endinterface

// File: rtl/s_to_p_pack.sv
// s_to_p_pack: packs valid slices LSB-first into wide words with eof flush and sync realign
module s_to_p_pack #(
  parameter int N_SLICES   = 4,
  parameter int SLICE_SIZE = 32,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst,
  s_to_p_pack_if.slave bus
);
  localparam int W  = N_SLICES * SLICE_SIZE;
  localparam int CW = $clog2(N_SLICES);
  logic [CW-1:0]       cnt_q, cnt_d, base_cnt;
  logic [W-1:0]        buf_q, buf_d, asm_buf, dout_q;
  logic [N_SLICES-1:0] mask_q, mask_d, asm_mask, dout_mask_q;
  logic [CNT_W-1:0]    dropped_q, dropped_d;
  logic                dout_vld_q, dout_last_q, emit;
  // sync clears the partial word before this edge's slice and eof are applied
  always_comb begin
    base_cnt = bus.sync ? '0 : cnt_q;
    asm_buf  = bus.sync ? '0 : buf_q;
    asm_mask = bus.sync ? '0 : mask_q;
    if (bus.din_vld) begin
      asm_buf[base_cnt*SLICE_SIZE +: SLICE_SIZE] = bus.din;
      asm_mask[base_cnt] = 1'b1;
    end
    emit      = (bus.din_vld && base_cnt == CW'(N_SLICES-1)) ||
                (bus.eof && (bus.din_vld || base_cnt != '0));
    cnt_d     = emit ? '0 : base_cnt + CW'(bus.din_vld);
    buf_d     = emit ? '0 : asm_buf;
    mask_d    = emit ? '0 : asm_mask;
    dropped_d = dropped_q + CNT_W'(bus.sync && cnt_q != '0 && !(&dropped_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      mask_q      <= '0;
      dout_q      <= '0;
      dout_mask_q <= '0;
      dout_last_q <= 1'b0;
      dout_vld_q  <= 1'b0;
      dropped_q   <= '0;
    end else begin
      dout_vld_q <= bus.ce && emit;
      if (bus.ce) begin
        cnt_q     <= cnt_d;
        buf_q     <= buf_d;
        mask_q    <= mask_d;
        dropped_q <= dropped_d;
        if (emit) begin
          dout_q      <= asm_buf;
          dout_mask_q <= asm_mask;
          dout_last_q <= bus.eof;
        end
      end
    end
  end
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.dout_mask = dout_mask_q;
  assign bus.dout_last = dout_last_q;
  assign bus.dropped   = dropped_q;
endmodule

// File: tb/tb_s_to_p_pack.sv
// tb_s_to_p_pack: directed vectors against two packers (16-bit and 2-bit drop counters)
module tb_s_to_p_pack;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, sync = 1'b0, din_vld = 1'b0, eof = 1'b0;
  logic [31:0] din = '0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  s_to_p_pack_if #(.N_SLICES(4), .SLICE_SIZE(32), .CNT_W(16)) ia ();
  s_to_p_pack_if #(.N_SLICES(4), .SLICE_SIZE(32), .CNT_W(2))  ib ();

  assign ia.ce = ce;  assign ia.sync = sync;  assign ia.din = din;
  assign ia.din_vld = din_vld;  assign ia.eof = eof;
  assign ib.ce = ce;  assign ib.sync = sync;  assign ib.din = din;
  assign ib.din_vld = din_vld;  assign ib.eof = eof;

  s_to_p_pack #(.N_SLICES(4), .SLICE_SIZE(32), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  s_to_p_pack #(.N_SLICES(4), .SLICE_SIZE(32), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic [31:0] d, input logic v, input logic e);
    ce = c; sync = s; din = d; din_vld = v; eof = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [127:0] d, input logic [3:0] m, input logic l);
    check({tag, "_vld"},  128'(ia.dout_vld), 128'(1));
    check({tag, "_dout"}, ia.dout, d);
    check({tag, "_mask"}, 128'(ia.dout_mask), 128'(m));
    check({tag, "_last"}, 128'(ia.dout_last), 128'(l));
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    check("rst_dout", ia.dout, 128'd0);
    check("rst_vld", 128'(ia.dout_vld), 128'd0);
    check("rst_mask", 128'(ia.dout_mask), 128'd0);
    check("rst_dropped", 128'(ia.dropped), 128'd0);
    rst = 1'b0;

    // full word
    step(1, 0, 32'h11, 1, 0);
    step(1, 0, 32'h22, 1, 0);
    step(1, 0, 32'h33, 1, 0);
    check("full_novld", 128'(ia.dout_vld), 128'd0);
    step(1, 0, 32'h44, 1, 0);
    check_word("full", {32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111, 1'b0);
    step(1, 0, 0, 0, 0);
    check("full_pulse", 128'(ia.dout_vld), 128'd0);
    check("full_hold", ia.dout, {32'h44, 32'h33, 32'h22, 32'h11});

    // eof flush, then eof on an empty word
    step(1, 0, 32'hA, 1, 0);
    step(1, 0, 32'hB, 1, 0);
    step(1, 0, 0, 0, 1);
    check_word("eof", {32'h0, 32'h0, 32'hB, 32'hA}, 4'b0011, 1'b1);
    step(1, 0, 0, 0, 1);
    check("eof_empty", 128'(ia.dout_vld), 128'd0);

    // sync realign with a slice on the same edge
    step(1, 0, 32'h1, 1, 0);
    step(1, 0, 32'h2, 1, 0);
    step(1, 0, 32'h3, 1, 0);
    step(1, 1, 32'h55, 1, 0);
    check("sync_novld", 128'(ia.dout_vld), 128'd0);
    check("sync_dropped", 128'(ia.dropped), 128'd1);
    step(1, 0, 32'h66, 1, 0);
    step(1, 0, 32'h77, 1, 0);
    check("sync_novld2", 128'(ia.dout_vld), 128'd0);
    step(1, 0, 32'h88, 1, 0);
    check_word("sync", {32'h88, 32'h77, 32'h66, 32'h55}, 4'b1111, 1'b0);

    // sync plus eof on the same edge
    step(1, 0, 32'h1, 1, 0);
    step(1, 1, 32'h99, 1, 1);
    check_word("synceof", {32'h0, 32'h0, 32'h0, 32'h99}, 4'b0001, 1'b1);
    check("synceof_dropped", 128'(ia.dropped), 128'd2);

    // ce gating: only ce=1 slices are packed
    step(1, 0, 32'hD1, 1, 0);
    step(0, 0, 32'hD2, 1, 0);
    step(1, 0, 32'hD3, 1, 0);
    step(0, 0, 32'hD4, 1, 0);
    step(1, 0, 32'hD5, 1, 0);
    step(0, 0, 32'hD6, 1, 0);
    check("ce_novld", 128'(ia.dout_vld), 128'd0);
    step(1, 0, 32'hD7, 1, 0);
    check_word("ce", {32'hD7, 32'hD5, 32'hD3, 32'hD1}, 4'b1111, 1'b0);
    step(0, 0, 32'hD8, 1, 0);
    check("ce_pulse", 128'(ia.dout_vld), 128'd0);
    check("ce_hold", ia.dout, {32'hD7, 32'hD5, 32'hD3, 32'hD1});

    // ce=0 blocks sync and eof
    step(1, 0, 32'hE1, 1, 0);
    step(0, 1, 32'h0, 0, 1);
    check("ce0_novld", 128'(ia.dout_vld), 128'd0);
    check("ce0_dropped", 128'(ia.dropped), 128'd2);

    // reset mid-word
    step(1, 0, 32'hE2, 1, 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 0);
    check("mrst_dout", ia.dout, 128'd0);
    check("mrst_mask", 128'(ia.dout_mask), 128'd0);
    check("mrst_last", 128'(ia.dout_last), 128'd0);
    check("mrst_dropped", 128'(ia.dropped), 128'd0);
    rst = 1'b0;
    step(1, 0, 32'hF1, 1, 0);
    check("mrst_post_vld", 128'(ia.dout_vld), 128'd0);
    check("mrst_post_dout", ia.dout, 128'd0);
    step(1, 0, 32'hF2, 1, 0);
    step(1, 0, 32'hF3, 1, 0);
    step(1, 0, 32'hF4, 1, 0);
    check_word("mrst", {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 4'b1111, 1'b0);
    check("mrst_word_dropped", 128'(ia.dropped), 128'd0);

    // saturation of the 2-bit drop counter
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 32'h5A, 1, 0);
      step(1, 1, 32'h0, 0, 0);
      check($sformatf("sat16_%0d", i), 128'(ia.dropped), 128'(i));
      check($sformatf("sat2_%0d", i), 128'(ib.dropped), 128'(i > 3 ? 3 : i));
    end
    step(1, 1, 32'h0, 0, 0);
    check("sat2_empty_sync", 128'(ib.dropped), 128'd3);
    check("sat16_empty_sync", 128'(ia.dropped), 128'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
